// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states,
// datapath select codes and the small decode helpers used by the controller.
package core_pkg;

    typedef enum logic [2:0] {
        ST_FETCH      = 3'd0,
        ST_DECODE     = 3'd1,
        ST_EXEC       = 3'd2,
        ST_MEM        = 3'd3,
        ST_WB         = 3'd4,
        ST_ECALL_WAIT = 3'd5,
        ST_HALT       = 3'd6,
        ST_TRAP       = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        PC_REL   = 2'b01,
        PC_JALR  = 2'b10
    } pc_src_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_CMP   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic    src_a;
        logic    src_b;
        alu_op_e op;
    } alu_ctrl_t;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    function automatic logic opcode_legal(input logic [6:0] opc, input logic [6:0] funct7);
        logic ok;
        ok = 1'b0;
        case (opc)
            OP_REG:  ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI,
            OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // ALU operand/op selection by instruction class; held past EXEC so an
    // unregistered ALU result stays valid through MEM and WB.
    function automatic alu_ctrl_t alu_ctrl(input logic [6:0] opc);
        alu_ctrl_t c;
        c = '0;
        case (opc)
            OP_REG:             c.op = ALU_FUNCT;
            OP_IMM:             begin c.src_b = 1'b1; c.op = ALU_FUNCT; end
            OP_AUIPC:           begin c.src_a = 1'b1; c.src_b = 1'b1; c.op = ALU_ADD; end
            OP_LOAD, OP_STORE:  begin c.src_b = 1'b1; c.op = ALU_ADD; end
            OP_BRANCH:          c.op = ALU_CMP;
            default:            c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller (master) and
// the shared datapath plus memory/I-O side (slave).
interface multicycle_ctrl_if;
    logic [31:0] inst;
    logic        br_taken;
    logic        imem_req;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        ecall_req;
    logic        ecall_ack;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        alu_src_a;
    logic        alu_src_b;
    logic [1:0]  alu_op;
    logic        halted;
    logic        bus_err;
    logic        illegal;
    logic [2:0]  state_o;

    modport master (
        input  inst, br_taken, imem_ready, dmem_ready, ecall_ack,
        output imem_req, dmem_req, dmem_we, ecall_req, ir_we, pc_we, pc_src,
               reg_write, wb_sel, alu_src_a, alu_src_b, alu_op,
               halted, bus_err, illegal, state_o
    );

    modport slave (
        output inst, br_taken, imem_ready, dmem_ready, ecall_ack,
        input  imem_req, dmem_req, dmem_we, ecall_req, ir_we, pc_we, pc_src,
               reg_write, wb_sel, alu_src_a, alu_src_b, alu_op,
               halted, bus_err, illegal, state_o
    );
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Wait-cycle counter shared by instruction fetch and data access; flags the
// last permitted wait cycle so the controller can give up on the bus.
module mem_wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic limit_o
);
    localparam int unsigned TW = $clog2(LIMIT + 1);
    localparam logic [TW-1:0] LAST = TW'(LIMIT - 1);
    localparam logic [TW-1:0] MAX  = TW'(LIMIT);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // This cycle's increment would reach the limit: a ready now still wins.
    assign limit_o = (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the multi-cycle RV32I core: drives every datapath
// enable and mux select, and runs the imem/dmem/ecall handshakes.
//
// state      | meaning
// FETCH      | imem_req until imem_ready, load IR
// DECODE     | classify opcode, trap on illegal
// EXEC       | ALU/branch/jump work, pick next phase
// MEM        | dmem_req until dmem_ready
// WB         | register write, PC+4
// ECALL_WAIT | ecall_req until ecall_ack (no timeout)
// HALT       | ebreak reached, idle until reset
// TRAP       | illegal instruction or bus timeout, idle until reset
module multicycle_ctrl
    import core_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

    state_e    state_q, state_d;
    logic      halted_q, halted_d;
    logic      bus_err_q, bus_err_d;
    logic      illegal_q, illegal_d;

    logic      imem_req, dmem_req, dmem_we, ecall_req;
    logic      ir_we, pc_we, reg_write;
    pc_src_e   pc_src;
    wb_sel_e   wb_sel;
    alu_ctrl_t alu;

    logic      tmr_clr, tmr_en, tmr_limit;
    logic [6:0] opcode;
    logic      is_store;
    logic      unused_inst_bits;

    assign opcode   = bus.inst[6:0];
    assign is_store = (opcode == OP_STORE);
    // Register indices, funct3 and immediates belong to the datapath.
    assign unused_inst_bits = ^{bus.inst[24:21], bus.inst[19:7]};

    always_comb begin
        state_d   = state_q;
        halted_d  = halted_q;
        bus_err_d = bus_err_q;
        illegal_d = illegal_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ecall_req = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_write = 1'b0;
        pc_src    = PC_PLUS4;
        wb_sel    = WB_ALU;
        alu       = '0;

        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (tmr_limit) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_TRAP;
                end
            end

            ST_DECODE: begin
                if (opcode_legal(opcode, bus.inst[31:25])) begin
                    state_d = ST_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end
            end

            ST_EXEC: begin
                alu = alu_ctrl(opcode);
                case (opcode)
                    OP_REG, OP_IMM, OP_LUI, OP_AUIPC: state_d = ST_WB;
                    OP_LOAD, OP_STORE:                state_d = ST_MEM;
                    OP_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_src  = bus.br_taken ? PC_REL : PC_PLUS4;
                        state_d = ST_FETCH;
                    end
                    OP_JAL, OP_JALR: begin
                        reg_write = 1'b1;
                        wb_sel    = WB_PC4;
                        pc_we     = 1'b1;
                        pc_src    = (opcode == OP_JAL) ? PC_REL : PC_JALR;
                        state_d   = ST_FETCH;
                    end
                    OP_SYSTEM: begin
                        if (bus.inst[20]) begin
                            halted_d = 1'b1;
                            state_d  = ST_HALT;
                        end else begin
                            state_d = ST_ECALL_WAIT;
                        end
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ST_TRAP;
                    end
                endcase
            end

            ST_MEM: begin
                alu      = alu_ctrl(opcode);
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (bus.dmem_ready) begin
                    if (is_store) begin
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (tmr_limit) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_TRAP;
                end
            end

            ST_WB: begin
                alu       = alu_ctrl(opcode);
                reg_write = 1'b1;
                pc_we     = 1'b1;
                if (opcode == OP_LOAD) begin
                    wb_sel = WB_MEM;
                end else if (opcode == OP_LUI) begin
                    wb_sel = WB_IMM;
                end
                state_d = ST_FETCH;
            end

            ST_ECALL_WAIT: begin
                ecall_req = 1'b1;
                if (bus.ecall_ack) begin
                    pc_we   = 1'b1;
                    state_d = ST_FETCH;
                end
            end

            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_FETCH;
            halted_q  <= 1'b0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            bus_err_q <= bus_err_d;
            illegal_q <= illegal_d;
        end
    end

    assign tmr_clr = (state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM));
    assign tmr_en  = ((state_q == ST_FETCH) && !bus.imem_ready) ||
                     ((state_q == ST_MEM)   && !bus.dmem_ready);

    mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (tmr_clr),
        .en_i    (tmr_en),
        .limit_o (tmr_limit)
    );

    // Outputs are forced low while reset is held so a request drops at once.
    assign bus.imem_req  = rst & imem_req;
    assign bus.dmem_req  = rst & dmem_req;
    assign bus.dmem_we   = rst & dmem_we;
    assign bus.ecall_req = rst & ecall_req;
    assign bus.ir_we     = rst & ir_we;
    assign bus.pc_we     = rst & pc_we;
    assign bus.reg_write = rst & reg_write;
    assign bus.pc_src    = rst ? 2'(pc_src) : 2'b00;
    assign bus.wb_sel    = rst ? 2'(wb_sel) : 2'b00;
    assign bus.alu_src_a = rst & alu.src_a;
    assign bus.alu_src_b = rst & alu.src_b;
    assign bus.alu_op    = rst ? 2'(alu.op) : 2'b00;
    assign bus.halted    = rst & halted_q;
    assign bus.bus_err   = rst & bus_err_q;
    assign bus.illegal   = rst & illegal_q;
    assign bus.state_o   = rst ? 3'(state_q) : 3'd0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl: walks each instruction class
// through the FSM and checks states, enables, selects and sticky flags.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    multicycle_ctrl_if bus_if ();

    multicycle_ctrl #(
        .MEM_TIMEOUT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and check the state the FSM is now in.
    task automatic step(input string tag, input logic [2:0] st);
        @(negedge clk);
        #1;
        check(tag, 32'(bus_if.state_o), 32'(st));
    endtask

    initial begin
        rst               = 1'b0;
        bus_if.inst       = 32'h0;
        bus_if.br_taken   = 1'b0;
        bus_if.imem_ready = 1'b0;
        bus_if.dmem_ready = 1'b0;
        bus_if.ecall_ack  = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_state", 32'(bus_if.state_o), 32'd0);
        check("rst_imem_req", 32'(bus_if.imem_req), 32'd0);
        check("rst_flags", 32'({bus_if.halted, bus_if.bus_err, bus_if.illegal}), 32'd0);

        // addi x1,x0,5 with zero-wait memory
        @(negedge clk);
        rst               = 1'b1;
        bus_if.inst       = 32'h00500093;
        bus_if.imem_ready = 1'b1;
        bus_if.dmem_ready = 1'b1;
        #1;
        check("addi_fetch_state", 32'(bus_if.state_o), 32'd0);
        check("addi_fetch_req_irwe", 32'({bus_if.imem_req, bus_if.ir_we}), 32'b11);
        step("addi_decode", 3'd1);
        step("addi_exec", 3'd2);
        check("addi_exec_alu", 32'({bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op}), 32'b0110);
        step("addi_wb", 3'd4);
        check("addi_wb_ctrl", 32'({bus_if.reg_write, bus_if.wb_sel, bus_if.pc_we, bus_if.pc_src}), 32'b100100);
        step("addi_done", 3'd0);

        // sub: R-type with the alternate funct7
        bus_if.inst = 32'h40208033;
        step("sub_decode", 3'd1);
        step("sub_exec", 3'd2);
        check("sub_exec_alu", 32'({bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op}), 32'b0010);
        step("sub_wb", 3'd4);
        step("sub_done", 3'd0);

        // lw with dmem_ready arriving on the 4th MEM cycle (the limit cycle)
        bus_if.inst       = 32'h0000A103;
        bus_if.dmem_ready = 1'b0;
        step("lw_decode", 3'd1);
        step("lw_exec", 3'd2);
        check("lw_exec_alu", 32'({bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op}), 32'b0100);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_if.dmem_ready = (i == 3);
            #1;
            check("lw_mem_state", 32'(bus_if.state_o), 32'd3);
            check("lw_mem_req_we_pcwe", 32'({bus_if.dmem_req, bus_if.dmem_we, bus_if.pc_we}), 32'b100);
        end
        step("lw_wb", 3'd4);
        check("lw_wb_ctrl", 32'({bus_if.reg_write, bus_if.wb_sel}), 32'b101);
        step("lw_done", 3'd0);

        // beq taken / not taken
        bus_if.inst     = 32'h00208463;
        bus_if.br_taken = 1'b1;
        step("beqt_decode", 3'd1);
        step("beqt_exec", 3'd2);
        check("beqt_pc", 32'({bus_if.pc_we, bus_if.pc_src, bus_if.alu_op}), 32'b10101);
        step("beqt_done", 3'd0);
        bus_if.br_taken = 1'b0;
        step("beqn_decode", 3'd1);
        step("beqn_exec", 3'd2);
        check("beqn_pc", 32'({bus_if.pc_we, bus_if.pc_src}), 32'b100);
        step("beqn_done", 3'd0);

        // jal and jalr
        bus_if.inst = 32'hff9ff06f;
        step("jal_decode", 3'd1);
        step("jal_exec", 3'd2);
        check("jal_ctrl", 32'({bus_if.reg_write, bus_if.wb_sel, bus_if.pc_we, bus_if.pc_src}), 32'b110101);
        step("jal_done", 3'd0);
        bus_if.inst = 32'h000080e7;
        step("jalr_decode", 3'd1);
        step("jalr_exec", 3'd2);
        check("jalr_ctrl", 32'({bus_if.reg_write, bus_if.wb_sel, bus_if.pc_we, bus_if.pc_src}), 32'b110110);
        step("jalr_done", 3'd0);

        // sw, zero wait: completes from MEM straight to FETCH
        bus_if.inst       = 32'h0020a023;
        bus_if.dmem_ready = 1'b1;
        step("sw_decode", 3'd1);
        step("sw_exec", 3'd2);
        step("sw_mem", 3'd3);
        check("sw_mem_ctrl", 32'({bus_if.dmem_req, bus_if.dmem_we, bus_if.pc_we, bus_if.pc_src, bus_if.reg_write}), 32'b111000);
        step("sw_done", 3'd0);

        // lui writes back the immediate
        bus_if.inst = 32'h123450b7;
        step("lui_decode", 3'd1);
        step("lui_exec", 3'd2);
        step("lui_wb", 3'd4);
        check("lui_wb_sel", 32'({bus_if.reg_write, bus_if.wb_sel}), 32'b111);
        step("lui_done", 3'd0);

        // ecall: long ack wait must not time out
        bus_if.inst = 32'h00000073;
        step("ecall_decode", 3'd1);
        step("ecall_exec", 3'd2);
        bus_if.imem_ready = 1'b0;
        bus_if.dmem_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step("ecall_wait_state", 3'd5);
            check("ecall_wait_req", 32'({bus_if.ecall_req, bus_if.pc_we}), 32'b10);
        end
        @(negedge clk);
        bus_if.ecall_ack  = 1'b1;
        bus_if.imem_ready = 1'b1;
        #1;
        check("ecall_ack_ctrl", 32'({bus_if.state_o, bus_if.ecall_req, bus_if.pc_we}), 32'b10111);
        @(negedge clk);
        bus_if.ecall_ack = 1'b0;
        #1;
        check("ecall_done", 32'(bus_if.state_o), 32'd0);

        // ebreak halts and stays halted
        bus_if.inst = 32'h00100073;
        step("ebreak_decode", 3'd1);
        step("ebreak_exec", 3'd2);
        step("ebreak_halt", 3'd6);
        check("ebreak_halted", 32'(bus_if.halted), 32'd1);
        step("ebreak_sticky", 3'd6);
        check("ebreak_quiet", 32'({bus_if.imem_req, bus_if.pc_we, bus_if.reg_write}), 32'd0);

        // illegal opcode
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst2_state_flags", 32'({bus_if.state_o, bus_if.halted}), 32'd0);
        @(negedge clk);
        rst         = 1'b1;
        bus_if.inst = 32'h0000007F;
        step("ill_decode", 3'd1);
        step("ill_trap", 3'd7);
        check("ill_flag", 32'(bus_if.illegal), 32'd1);
        check("ill_quiet", 32'({bus_if.imem_req, bus_if.ir_we, bus_if.pc_we, bus_if.reg_write}), 32'd0);

        // R-type with a funct7 outside the base ISA
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst         = 1'b1;
        bus_if.inst = 32'h02208033;
        step("f7_decode", 3'd1);
        step("f7_trap", 3'd7);
        check("f7_illegal", 32'(bus_if.illegal), 32'd1);

        // fetch timeout with MEM_TIMEOUT=4
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst               = 1'b1;
        bus_if.imem_ready = 1'b0;
        #1;
        check("to_wait0", 32'({bus_if.state_o, bus_if.imem_req}), 32'b0001);
        for (int i = 1; i < 4; i++) begin
            step("to_wait_state", 3'd0);
            check("to_wait_req", 32'(bus_if.imem_req), 32'd1);
        end
        step("to_trap", 3'd7);
        check("to_flags_req", 32'({bus_if.bus_err, bus_if.illegal, bus_if.imem_req}), 32'b100);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("to_rst_state", 32'(bus_if.state_o), 32'd0);
        check("to_rst_flags_req", 32'({bus_if.halted, bus_if.bus_err, bus_if.illegal, bus_if.imem_req}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I core. It sequences the shared datapath (PC, instruction register, decoder/register file, ALU, data memory) through fetch, decode, execute, memory and write-back.
- Handles the instruction-memory, data-memory and ecall-I/O handshakes, with a bounded memory wait.
- Emits all datapath enables and mux selects; holds no datapath values itself.

Parameters:
- MEM_TIMEOUT, 255, maximum wait cycles for imem_ready/dmem_ready before a bus error; legal range 1..65535.
- TW, $clog2(MEM_TIMEOUT+1), width of the wait counter (localparam, derived).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- inst  in  32  current instruction-register contents
- br_taken  in  1  branch-comparator result for the current instruction
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid this cycle
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- dmem_ready  in  1  data access complete this cycle
- ecall_req  out  1  board I/O service request
- ecall_ack  in  1  I/O service complete
- ir_we  out  1  load instruction register
- pc_we  out  1  update PC
- pc_src  out  2  00 PC+4, 01 PC+imm (branch/jal), 10 (rs1+imm)&~1 (jalr)
- reg_write  out  1  register-file write enable
- wb_sel  out  2  00 ALU, 01 memory, 10 PC+4, 11 imm
- alu_src_a  out  1  0 rs1, 1 PC
- alu_src_b  out  1  0 rs2, 1 imm
- alu_op  out  2  00 ADD, 01 COMPARE (funct3), 10 FUNCT (funct3/funct7)
- halted  out  1  ebreak reached; sticky
- bus_err  out  1  memory timeout; sticky
- illegal  out  1  illegal instruction; sticky
- state_o  out  3  current state, for debug LEDs

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ECALL_WAIT=5, HALT=6, TRAP=7. Registered state; outputs are a combinational function of state, inst and the handshake inputs.
- Reset (asynchronous, active low): state becomes FETCH, wait counter 0, sticky flags 0. While rst is low all outputs are 0 and state_o is 0.
- Reset in the middle of a handshake drops req immediately. No partial writes occur.
- FETCH:
  - imem_req=1 held until imem_ready.
  - On the imem_ready cycle: ir_we=1, next state DECODE.
  - A ready that arrives in the same cycle as the request is accepted, so the fetch takes 1 cycle.
- DECODE:
  - One cycle; classifies opcode.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111, 1110011.
  - R-type is also illegal if funct7 is not 0000000 or 0100000.
  - Illegal → TRAP with illegal=1; otherwise next state EXEC.
- EXEC:
  - R/I-ALU: alu_src_a=0, alu_src_b=(I?1:0), alu_op=10 → WB.
  - LUI: → WB.
  - AUIPC: alu_src_a=1, alu_src_b=1, alu_op=00 → WB.
  - Load/store: alu_op=00, alu_src_b=1 → MEM.
  - Branch: alu_op=01, pc_we=1, pc_src=(br_taken?01:00) → FETCH.
  - JAL: reg_write=1, wb_sel=10, pc_we=1, pc_src=01 → FETCH.
  - JALR: same as JAL with pc_src=10.
  - 1110011 with inst[20]=0 (ecall) → ECALL_WAIT. With inst[20]=1 (ebreak) → HALT.
- MEM:
  - dmem_req=1, dmem_we=(store), held until dmem_ready.
  - On ready: a store also sets pc_we=1, pc_src=00 → FETCH; a load → WB.
- WB:
  - reg_write=1, pc_we=1, pc_src=00 → FETCH.
  - wb_sel: 01 for load, 11 for LUI, otherwise 00.
- ECALL_WAIT:
  - ecall_req=1 until ecall_ack. This wait has no timeout.
  - On the ack cycle: pc_we=1, pc_src=00 → FETCH.
- HALT and TRAP: all enables 0. Only reset leaves these states.
- Wait counter:
  - Clears on entry to FETCH or MEM and increments each cycle that ready is low.
  - If it reaches MEM_TIMEOUT with ready still low → TRAP, bus_err=1, req deasserted.
  - A ready on the same cycle the counter reaches the limit takes priority: the access completes.
- Handshake inputs are ignored in states that do not request them. The controller asserts reg_write even for rd=x0; the register file suppresses that write.
- Latency with zero-wait memory:
  - ALU/LUI/AUIPC: 4 cycles
  - Load: 5 cycles
  - Store: 4 cycles
  - Branch/JAL/JALR: 3 cycles
  - Ecall: 3 cycles plus the I/O wait.

Decomposition:
- Package core_pkg holds:
  - opcode constants
  - state encoding
  - pc_src, wb_sel and alu_op encodings
  - the R-type funct7 legal values.
- One sub-module, mem_wait_timer, provides the clear/enable counter with a limit flag. It has a single instance shared by FETCH and MEM.

Test Plan:
- Release reset; inst=0x00500093 (addi x1,x0,5), ready tied high → state sequence 0,1,2,4,0. In WB: reg_write=1, wb_sel=00, pc_we=1, pc_src=00.
- Load 0x0000A103 with dmem_ready delayed 3 cycles → dmem_req high 4 cycles with dmem_we=0, then WB with wb_sel=01. Total 8 cycles.
- Branch 0x00208463 with br_taken=1 → pc_we=1, pc_src=01 in EXEC; back to FETCH after 3 cycles. With br_taken=0 → pc_src=00.
- JAL inst=0xff9ff06f → in EXEC: reg_write=1, wb_sel=10, pc_src=01, pc_we=1; next state FETCH.
- MEM_TIMEOUT=4 and imem_ready held low → after 4 wait cycles state_o=7, bus_err=1, imem_req=0. Then pulse rst low mid-TRAP → state_o=0, flags cleared.
- Ecall 0x00000073 with ack after 10 cycles → ecall_req high until the ack cycle, then pc_we=1. Illegal 0x0000007F → illegal=1, state 7. Ebreak 0x00100073 → halted=1.
